step_pulse_gen: RTL

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/step_pulse_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the DE2 push-button input blocks:
// FSM state encoding, default timing parameters and counter sizing helpers.
package step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } step_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
    localparam int unsigned DEF_REPEAT_DELAY    = 32'd25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 32'd5000000;

    // Bits needed to hold values 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level into the CLOCK_50 domain.
module sync_2ff (
    input  logic CLOCK_50,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stage registers with synchronous clear.
    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced push-button to single-cycle step pulse, with optional auto-repeat
// while held and a wrapping count of issued steps.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       CLOCK_50,
    input  logic       clr,
    input  logic       btn_raw,
    input  logic       rep_en,
    output logic       step,
    output logic       btn_level,
    output logic [7:0] step_count
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RT_W  = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [RT_W-1:0]  RT_ONE   = RT_W'(32'd1);
    localparam logic [RT_W-1:0]  RT_FIRST = RT_W'((REPEAT_DELAY > 32'd0) ? REPEAT_DELAY - 32'd1 : 32'd0);
    localparam logic [RT_W-1:0]  RT_NEXT  = RT_W'((REPEAT_PERIOD > 32'd0) ? REPEAT_PERIOD - 32'd1 : 32'd0);

    logic s;

    sync_2ff u_sync (
        .CLOCK_50 (CLOCK_50),
        .clr      (clr),
        .d        (btn_raw),
        .q        (s)
    );

    step_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RT_W-1:0]  rt_q, rt_d;
    logic             phase_q, phase_d;
    logic             step_q, step_d;
    logic             level_q, level_d;
    logic [7:0]       count_q, count_d;

    // Next-state and output logic of the press/hold/release FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rt_d    = rt_q;
        phase_d = phase_q;
        step_d  = 1'b0;
        level_d = level_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s) begin
                    state_d = ST_PRESS_DB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS_DB: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    level_d = 1'b1;
                    step_d  = 1'b1;
                    rt_d    = '0;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // rt only advances while the button is seen held, so a rejected
            // release glitch delays the repeat cadence instead of resetting it.
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end else if (!rep_en) begin
                    rt_d    = '0;
                    phase_d = 1'b0;
                end else if (rt_q == (phase_q ? RT_NEXT : RT_FIRST)) begin
                    step_d  = 1'b1;
                    rt_d    = '0;
                    phase_d = 1'b1;
                end else begin
                    rt_d = rt_q + RT_ONE;
                end
            end
            ST_RELEASE_DB: begin
                if (s) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rt_d    = '0;
                phase_d = 1'b0;
                level_d = 1'b0;
            end
        endcase

        if (step_d) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State and output registers; clr overrides everything, including a due step.
    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rt_q    <= '0;
            phase_q <= 1'b0;
            step_q  <= 1'b0;
            level_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rt_q    <= rt_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    assign step       = step_q;
    assign btn_level  = level_q;
    assign step_count = count_q;

endmodule
